group_a_handshake: RTL and testbench
====================================

GROUP_A_HANDSHAKE -- requirements
Module: group_a_handshake

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on stb_n and ack_n (minimum 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port mode_load  input  1  one-cycle pulse; a group A mode-1 control word was written.
REQ-005 SHALL have port dir_in  input  1  port A direction, sampled on mode_load: 1 = input, 0 = output.
REQ-006 SHALL have ports inte_set and inte_clr  input  1 each  one-cycle bit set/reset pulses for INTE A.
REQ-007 SHALL have ports rd_a_n and wr_a_n  input  1 each  CPU port A read/write strobes, synchronous to clk, active-low.
REQ-008 SHALL have ports stb_n and ack_n  input  1 each  asynchronous peripheral strobe and acknowledge (upper port C pins PC4 and PC6).
REQ-009 SHALL have ports pa_in  input  8  and cpu_din  input  8  data from peripheral and from CPU.
REQ-010 SHALL have ports pa_latch  output  8  and pa_out  output  8  data held for the CPU and for the peripheral.
REQ-011 SHALL have ports ibf, obf_n, intr, inte, overrun  output  1 each  handshake flags driven onto the upper port C nibble.

Function
REQ-012 SHALL implement states IDLE, IN_STB, IN_FULL, OUT_FULL and OUT_ACK.
REQ-013 In input mode, the state SHALL move IDLE->IN_STB on a synchronized stb_n falling edge, latching pa_in into pa_latch and setting ibf=1 in the same cycle.
REQ-014 IN_STB->IN_FULL SHALL occur on the stb_n rising edge, setting intr=inte.
REQ-015 In IN_FULL, a rd_a_n falling edge SHALL clear intr, and the rd_a_n rising edge SHALL clear ibf and return the state to IDLE.
REQ-016 In output mode, a wr_a_n rising edge in IDLE SHALL latch cpu_din into pa_out, drive obf_n=0 and intr=0, and move the state to OUT_FULL.
REQ-017 OUT_FULL->OUT_ACK SHALL occur on an ack_n falling edge, driving obf_n=1.
REQ-018 OUT_ACK->IDLE SHALL occur on the ack_n rising edge, setting intr=inte.
REQ-019 ibf SHALL assert on the clk edge SYNC_STAGES+1 after the first edge that samples stb_n low.
REQ-020 A stb_n falling edge in IN_STB or IN_FULL SHALL leave pa_latch unchanged and set overrun; overrun SHALL clear on the next rd_a_n rising edge.
REQ-021 A wr_a_n rising edge in OUT_FULL or OUT_ACK SHALL overwrite pa_out and keep obf_n=0, with the state moving to OUT_FULL.
REQ-022 inte_set and inte_clr SHALL take effect the next cycle; if both are asserted, clear SHALL win. Clearing inte while intr=1 SHALL drop intr the same cycle.
REQ-023 Strobes of the wrong direction (e.g. stb_n in output mode) SHALL be ignored.
REQ-024 When mode_load coincides with any event, mode_load SHALL win.

Reset
REQ-025 While rst_n=0, the block SHALL force state=IDLE, dir=input, ibf=0, obf_n=1, intr=0, inte=0, overrun=0, pa_latch=0, pa_out=0, and synchronizer flops to 1.
REQ-026 mode_load SHALL apply the reset values above, except for dir and the synchronizers, and SHALL abort any transfer in progress.

Structure
REQ-027 Package ppi_pkg SHALL hold the state enum, the DIR_IN/DIR_OUT constants and the width constant PORT_W=8.
REQ-028 Sub-module edge_sync (SYNC_STAGES-flop synchronizer with registered rise/fall pulses) SHALL be instantiated twice, once for stb_n and once for ack_n.

Verification
REQ-029 Bench SHALL cover: input mode, inte=1, pa_in=8'hA5, stb_n low 4 clk -> ibf=1 at cycle 3, pa_latch=A5, intr=1 after stb_n rises; rd_a_n pulse -> intr=0 then ibf=0.
REQ-030 Bench SHALL cover: output mode, inte=1, wr_a_n pulse with cpu_din=8'h3C -> pa_out=3C, obf_n=0; ack_n pulse -> obf_n=1 on the fall, intr=1 on the rise.
REQ-031 Bench SHALL cover: IN_FULL holding 8'h11, second stb_n with pa_in=8'h22 -> pa_latch stays 11, overrun=1; rd_a_n -> overrun=0.
REQ-032 Bench SHALL cover: inte_set and inte_clr in the same cycle while intr=1 -> inte=0 and intr=0 next cycle.
REQ-033 Bench SHALL cover: rst_n asserted mid-IN_STB and separately mode_load mid-OUT_FULL -> all flags at reset values, state IDLE; a subsequent transfer completes normally.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255-style group A mode-1 handshake slice.
package ppi_pkg;

    localparam int PORT_W = 8;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_STB   = 3'd1,
        IN_FULL  = 3'd2,
        OUT_FULL = 3'd3,
        OUT_ACK  = 3'd4
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous active-low pin, with registered
// one-cycle rise/fall pulses. Everything resets to the pin's idle-high level.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              last_reg;
    logic              rise_reg;
    logic              fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '1;
            last_reg <= 1'b1;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            last_reg <= sync_reg[STAGES-1];
            rise_reg <= ~last_reg & sync_reg[STAGES-1];
            fall_reg <= last_reg & ~sync_reg[STAGES-1];
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/group_a_handshake.sv
// Group A mode-1 strobed handshake: input latch on STB/IBF, output latch on
// OBF/ACK, with INTE-gated interrupt and an overrun flag for lost strobes.
module group_a_handshake
    import ppi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_load,
    input  logic              dir_in,
    input  logic              inte_set,
    input  logic              inte_clr,
    input  logic              rd_a_n,
    input  logic              wr_a_n,
    input  logic              stb_n,
    input  logic              ack_n,
    input  logic [PORT_W-1:0] pa_in,
    input  logic [PORT_W-1:0] cpu_din,
    output logic [PORT_W-1:0] pa_latch,
    output logic [PORT_W-1:0] pa_out,
    output logic              ibf,
    output logic              obf_n,
    output logic              intr,
    output logic              inte,
    output logic              overrun
);

    logic stb_rise, stb_fall, ack_rise, ack_fall;

    edge_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (stb_n),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    edge_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ack_n),
        .rise  (ack_rise),
        .fall  (ack_fall)
    );

    state_t              state_reg, state_next;
    logic                dir_reg, dir_next;
    logic                ibf_reg, ibf_next;
    logic                obf_n_reg, obf_n_next;
    logic                intr_reg, intr_next;
    logic                inte_reg, inte_next;
    logic                overrun_reg, overrun_next;
    logic [PORT_W-1:0]   pa_latch_reg, pa_latch_next;
    logic [PORT_W-1:0]   pa_out_reg, pa_out_next;
    logic                rd_prev_reg, wr_prev_reg;

    // CPU strobes are already clk-synchronous, so one history flop suffices.
    logic rd_fall, rd_rise, wr_rise;
    assign rd_fall = rd_prev_reg & ~rd_a_n;
    assign rd_rise = ~rd_prev_reg & rd_a_n;
    assign wr_rise = ~wr_prev_reg & wr_a_n;

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        ibf_next      = ibf_reg;
        obf_n_next    = obf_n_reg;
        intr_next     = intr_reg;
        overrun_next  = overrun_reg;
        pa_latch_next = pa_latch_reg;
        pa_out_next   = pa_out_reg;

        if (inte_clr)
            inte_next = 1'b0;
        else if (inte_set)
            inte_next = 1'b1;
        else
            inte_next = inte_reg;

        if (mode_load) begin
            state_next    = IDLE;
            dir_next      = dir_in;
            ibf_next      = 1'b0;
            obf_n_next    = 1'b1;
            intr_next     = 1'b0;
            inte_next     = 1'b0;
            overrun_next  = 1'b0;
            pa_latch_next = '0;
            pa_out_next   = '0;
        end else if (dir_reg == DIR_IN) begin
            if (stb_fall) begin
                if (state_reg == IDLE) begin
                    pa_latch_next = pa_in;
                    ibf_next      = 1'b1;
                    state_next    = IN_STB;
                end else begin
                    overrun_next = 1'b1;
                end
            end
            if (stb_rise && state_reg == IN_STB) begin
                state_next = IN_FULL;
                intr_next  = inte_next;
            end
            if (rd_fall && state_reg == IN_FULL)
                intr_next = 1'b0;
            // The read that empties the buffer also retires any overrun.
            if (rd_rise) begin
                overrun_next = 1'b0;
                if (state_reg == IN_FULL) begin
                    ibf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
        end else begin
            if (wr_rise) begin
                pa_out_next = cpu_din;
                obf_n_next  = 1'b0;
                intr_next   = 1'b0;
                state_next  = OUT_FULL;
            end else if (ack_fall && state_reg == OUT_FULL) begin
                obf_n_next = 1'b1;
                state_next = OUT_ACK;
            end else if (ack_rise && state_reg == OUT_ACK) begin
                intr_next  = inte_next;
                state_next = IDLE;
            end
        end

        intr_next = intr_next & inte_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            dir_reg      <= DIR_IN;
            ibf_reg      <= 1'b0;
            obf_n_reg    <= 1'b1;
            intr_reg     <= 1'b0;
            inte_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
            pa_latch_reg <= '0;
            pa_out_reg   <= '0;
            rd_prev_reg  <= 1'b1;
            wr_prev_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            ibf_reg      <= ibf_next;
            obf_n_reg    <= obf_n_next;
            intr_reg     <= intr_next;
            inte_reg     <= inte_next;
            overrun_reg  <= overrun_next;
            pa_latch_reg <= pa_latch_next;
            pa_out_reg   <= pa_out_next;
            rd_prev_reg  <= rd_a_n;
            wr_prev_reg  <= wr_a_n;
        end
    end

    assign pa_latch = pa_latch_reg;
    assign pa_out   = pa_out_reg;
    assign ibf      = ibf_reg;
    assign obf_n    = obf_n_reg;
    assign intr     = intr_reg;
    assign inte     = inte_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_group_a_handshake.sv
// Self-checking bench: directed handshake scenarios plus random traffic,
// compared every cycle against a sample-history reference model.
module tb_group_a_handshake;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_load = 1'b0, dir_in = 1'b1;
    logic       inte_set = 1'b0, inte_clr = 1'b0;
    logic       rd_a_n = 1'b1, wr_a_n = 1'b1, stb_n = 1'b1, ack_n = 1'b1;
    logic [7:0] pa_in = 8'h00, cpu_din = 8'h00;
    logic [7:0] pa_latch, pa_out;
    logic       ibf, obf_n, intr, inte, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 1'b0;

    group_a_handshake #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_load (mode_load),
        .dir_in    (dir_in),
        .inte_set  (inte_set),
        .inte_clr  (inte_clr),
        .rd_a_n    (rd_a_n),
        .wr_a_n    (wr_a_n),
        .stb_n     (stb_n),
        .ack_n     (ack_n),
        .pa_in     (pa_in),
        .cpu_din   (cpu_din),
        .pa_latch  (pa_latch),
        .pa_out    (pa_out),
        .ibf       (ibf),
        .obf_n     (obf_n),
        .intr      (intr),
        .inte      (inte),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: pin samples kept as a history so that an asynchronous
    // edge is seen S+1 clocks after the first sample showing the new level.
    logic [S+2:0] m_stb_hist, m_ack_hist;
    logic m_rd_prev, m_wr_prev;
    logic m_dir, m_ibf, m_obf_n, m_intr, m_inte, m_ovr;
    logic [7:0] m_latch, m_out;
    bit m_in_stb, m_in_full, m_out_full, m_out_ack;

    task automatic model_reset();
        m_stb_hist = '1; m_ack_hist = '1;
        m_rd_prev = 1'b1; m_wr_prev = 1'b1;
        m_dir = 1'b1; m_ibf = 1'b0; m_obf_n = 1'b1; m_intr = 1'b0;
        m_inte = 1'b0; m_ovr = 1'b0; m_latch = 8'h00; m_out = 8'h00;
        m_in_stb = 0; m_in_full = 0; m_out_full = 0; m_out_ack = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit sf, sr, af, ar, rf, rr, wr, inte_n;
                bit p_stb, p_full, p_of, p_oa;
                m_stb_hist = {m_stb_hist[S+1:0], stb_n};
                m_ack_hist = {m_ack_hist[S+1:0], ack_n};
                sf = m_stb_hist[S+2] & ~m_stb_hist[S+1];
                sr = ~m_stb_hist[S+2] & m_stb_hist[S+1];
                af = m_ack_hist[S+2] & ~m_ack_hist[S+1];
                ar = ~m_ack_hist[S+2] & m_ack_hist[S+1];
                rf = m_rd_prev & ~rd_a_n;
                rr = ~m_rd_prev & rd_a_n;
                wr = ~m_wr_prev & wr_a_n;
                m_rd_prev = rd_a_n;
                m_wr_prev = wr_a_n;
                inte_n = inte_clr ? 1'b0 : (inte_set ? 1'b1 : m_inte);
                p_stb = m_in_stb; p_full = m_in_full;
                p_of = m_out_full; p_oa = m_out_ack;
                if (mode_load) begin
                    m_dir = dir_in; m_ibf = 0; m_obf_n = 1; m_intr = 0;
                    inte_n = 0; m_ovr = 0; m_latch = 8'h00; m_out = 8'h00;
                    m_in_stb = 0; m_in_full = 0; m_out_full = 0; m_out_ack = 0;
                end else if (m_dir) begin
                    if (sf) begin
                        if (!p_stb && !p_full) begin
                            m_latch = pa_in; m_ibf = 1; m_in_stb = 1;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                    if (sr && p_stb) begin
                        m_in_stb = 0; m_in_full = 1; m_intr = inte_n;
                    end
                    if (rf && p_full) m_intr = 0;
                    if (rr) begin
                        m_ovr = 0;
                        if (p_full) begin m_in_full = 0; m_ibf = 0; end
                    end
                end else begin
                    if (wr) begin
                        m_out = cpu_din; m_obf_n = 0; m_intr = 0;
                        m_out_full = 1; m_out_ack = 0;
                    end else if (af && p_of) begin
                        m_obf_n = 1; m_out_full = 0; m_out_ack = 1;
                    end else if (ar && p_oa) begin
                        m_out_ack = 0; m_intr = inte_n;
                    end
                end
                m_inte = inte_n;
                m_intr = m_intr & inte_n;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            n_cmp++;
            if ({ibf, obf_n, intr, inte, overrun, pa_latch, pa_out} !==
                {m_ibf, m_obf_n, m_intr, m_inte, m_ovr, m_latch, m_out}) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t: dut ibf=%b obf_n=%b intr=%b inte=%b ovr=%b latch=%h out=%h / model ibf=%b obf_n=%b intr=%b inte=%b ovr=%b latch=%h out=%h",
                         $time, ibf, obf_n, intr, inte, overrun, pa_latch, pa_out,
                         m_ibf, m_obf_n, m_intr, m_inte, m_ovr, m_latch, m_out);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_mode(input logic d);
        mode_load = 1'b1; dir_in = d; idle(1);
        mode_load = 1'b0;
    endtask

    task automatic set_inte();
        inte_set = 1'b1; idle(1);
        inte_set = 1'b0;
    endtask

    task automatic stb_pulse(input int low);
        stb_n = 1'b0; idle(low);
        stb_n = 1'b1; idle(1);
    endtask

    task automatic ack_pulse(input int low);
        ack_n = 1'b0; idle(low);
        ack_n = 1'b1; idle(1);
    endtask

    task automatic rd_pulse();
        rd_a_n = 1'b0; idle(1);
        rd_a_n = 1'b1; idle(1);
    endtask

    task automatic wr_pulse(input logic [7:0] d, input int low);
        cpu_din = d; wr_a_n = 1'b0; idle(low);
        wr_a_n = 1'b1; idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("reset_ibf", {7'd0, ibf}, 8'd0);
        chk("reset_obf_n", {7'd0, obf_n}, 8'd1);
        chk("reset_flags", {5'd0, intr, inte, overrun}, 8'd0);
        chk("reset_pa_latch", pa_latch, 8'h00);

        // Input transfer: IBF latency, latch, INTR, read sequence.
        load_mode(1'b1);
        set_inte();
        pa_in = 8'hA5;
        stb_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("ibf_edge%0d", k), {7'd0, ibf}, (k == 3) ? 8'd1 : 8'd0);
        end
        @(negedge clk);
        stb_n = 1'b1;
        idle(6);
        chk("in_pa_latch", pa_latch, 8'hA5);
        chk("in_intr_rise", {7'd0, intr}, 8'd1);
        rd_a_n = 1'b0; idle(1);
        chk("rd_fall_intr", {7'd0, intr}, 8'd0);
        chk("rd_fall_ibf", {7'd0, ibf}, 8'd1);
        rd_a_n = 1'b1; idle(1);
        chk("rd_rise_ibf", {7'd0, ibf}, 8'd0);

        // Output transfer.
        load_mode(1'b0);
        set_inte();
        wr_pulse(8'h3C, 1);
        chk("out_pa_out", pa_out, 8'h3C);
        chk("out_obf_n_low", {7'd0, obf_n}, 8'd0);
        ack_n = 1'b0; idle(3);
        chk("obf_before_ack", {7'd0, obf_n}, 8'd0);
        idle(1);
        chk("obf_on_ack_fall", {7'd0, obf_n}, 8'd1);
        chk("intr_on_ack_fall", {7'd0, intr}, 8'd0);
        ack_n = 1'b1; idle(4);
        chk("intr_on_ack_rise", {7'd0, intr}, 8'd1);

        // Overrun while full.
        load_mode(1'b1);
        set_inte();
        pa_in = 8'h11; stb_pulse(2); idle(6);
        chk("ovr_first_latch", pa_latch, 8'h11);
        pa_in = 8'h22; stb_pulse(2); idle(6);
        chk("ovr_latch_held", pa_latch, 8'h11);
        chk("ovr_set", {7'd0, overrun}, 8'd1);
        rd_pulse();
        chk("ovr_cleared", {7'd0, overrun}, 8'd0);
        chk("ovr_ibf_cleared", {7'd0, ibf}, 8'd0);

        // Simultaneous set/clear of INTE while INTR is high.
        pa_in = 8'h44; stb_pulse(2); idle(6);
        chk("inte_pre_intr", {7'd0, intr}, 8'd1);
        inte_set = 1'b1; inte_clr = 1'b1; idle(1);
        inte_set = 1'b0; inte_clr = 1'b0;
        chk("inte_clr_wins", {7'd0, inte}, 8'd0);
        chk("inte_clr_intr", {7'd0, intr}, 8'd0);
        rd_pulse();

        // Async reset in the middle of a strobe.
        set_inte();
        pa_in = 8'h99;
        stb_n = 1'b0; idle(4);
        chk("mid_stb_ibf", {7'd0, ibf}, 8'd1);
        rst_n = 1'b0; stb_n = 1'b1;
        #1;
        chk("rst_mid_ibf", {7'd0, ibf}, 8'd0);
        chk("rst_mid_latch", pa_latch, 8'h00);
        chk("rst_mid_flags", {5'd0, intr, inte, overrun}, 8'd0);
        idle(2);
        rst_n = 1'b1; idle(1);
        set_inte();
        pa_in = 8'h5A; stb_pulse(2); idle(6);
        chk("post_rst_latch", pa_latch, 8'h5A);
        chk("post_rst_intr", {7'd0, intr}, 8'd1);
        rd_pulse();
        chk("post_rst_ibf", {7'd0, ibf}, 8'd0);

        // mode_load aborting a pending output.
        load_mode(1'b0);
        set_inte();
        wr_pulse(8'h77, 1);
        chk("pre_abort_obf", {7'd0, obf_n}, 8'd0);
        load_mode(1'b0);
        chk("abort_obf", {7'd0, obf_n}, 8'd1);
        chk("abort_pa_out", pa_out, 8'h00);
        chk("abort_flags", {5'd0, intr, inte, overrun}, 8'd0);
        set_inte();
        wr_pulse(8'h88, 2);
        ack_pulse(2); idle(8);
        chk("post_abort_out", pa_out, 8'h88);
        chk("post_abort_intr", {7'd0, intr}, 8'd1);

        // Random traffic, checked by the per-cycle compare.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0: load_mode(1'($urandom_range(0, 1)));
                1: begin
                    inte_set = 1'($urandom_range(0, 1));
                    inte_clr = ($urandom_range(0, 3) == 0);
                    idle(1);
                    inte_set = 1'b0; inte_clr = 1'b0;
                end
                2, 3: stb_pulse($urandom_range(1, 4));
                4: rd_pulse();
                5, 6: wr_pulse(8'($urandom), $urandom_range(1, 2));
                7: ack_pulse($urandom_range(1, 4));
                8: begin pa_in = 8'($urandom); idle(1); end
                default: idle(1);
            endcase
            idle($urandom_range(0, 5));
        end
        idle(8);

        done = 1'b1;
        @(posedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
